// File: rtl/banner_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// banner_scroll_ctrl
//
// Purpose
//    Sequences a banner glyph ROM (one 57-bit pixel line per address, read
//    through a 1-cycle registered address) and streams DISP_ROWS consecutive
//    lines, starting at the current scroll offset, to an LED-matrix row driver
//    over a valid/ready handshake. A free-running divider advances the scroll
//    offset so the banner moves across the display.
//
// Ports
//    clk          in   1      system clock
//    rst_n        in   1      asynchronous reset, active low
//    enable       in   1      0: divider frozen, frame_start ignored
//    pause        in   1      1: divider frozen, frames still served
//    frame_start  in   1      one-cycle request to send one frame
//    rom_addr     out  8      ROM address (registered)
//    rom_data     in   57     ROM line, valid 2nd cycle after rom_addr changes
//    row_data     out  57     line presented to the row driver
//    row_idx      out  ROW_W  display row of row_data
//    row_valid    out  1      row_data/row_idx valid
//    row_ready    in   1      driver accepts when row_valid && row_ready
//    frame_done   out  1      one-cycle pulse after the last row is accepted
//    busy         out  1      high in every state except IDLE
//    scroll_pos   out  8      current scroll offset
//
// Configuration
//    BANNER_BOUNCE_EN  when defined, the offset ping-pongs between 0 and
//                      BANNER_LEN-DISP_ROWS instead of wrapping modulo
//                      BANNER_LEN. Default build: modulo wrap.
// -----------------------------------------------------------------------------
module banner_scroll_ctrl #(
   parameter int unsigned BANNER_LEN = 129,
   parameter int unsigned DISP_ROWS  = 16,
   parameter int unsigned SCROLL_DIV = 2500000,
   parameter int unsigned ROW_W      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             pause,
   input  logic             frame_start,
   output logic [7:0]       rom_addr,
   input  logic [56:0]      rom_data,
   output logic [56:0]      row_data,
   output logic [ROW_W-1:0] row_idx,
   output logic             row_valid,
   input  logic             row_ready,
   output logic             frame_done,
   output logic             busy,
   output logic [7:0]       scroll_pos
);

   localparam int unsigned    DIV_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
   localparam logic [7:0]     POS_LAST = 8'(BANNER_LEN - 1);
   localparam logic [8:0]     LEN_9    = 9'(BANNER_LEN);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DISP_ROWS - 1);
`ifdef BANNER_BOUNCE_EN
   localparam logic [7:0]     POS_TOP  = 8'(BANNER_LEN - DISP_ROWS);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_FETCH,
      S_HOLD
   } state_t;

`ifdef BANNER_BOUNCE_EN
   typedef enum logic {
      DIR_FWD,
      DIR_REV
   } dir_t;
`endif

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t           state_q,      state_d;
   logic [7:0]       base_q,       base_d;
   logic [ROW_W-1:0] row_q,        row_d;
   logic [7:0]       rom_addr_q,   rom_addr_d;
   logic [56:0]      row_data_q,   row_data_d;
   logic [ROW_W-1:0] row_idx_q,    row_idx_d;
   logic             row_valid_q,  row_valid_d;
   logic             frame_done_q, frame_done_d;
   logic [DIV_W-1:0] div_q,        div_d;
   logic [7:0]       pos_q,        pos_d;
`ifdef BANNER_BOUNCE_EN
   dir_t             dir_q,        dir_d;
`endif

   logic             div_run;
   logic             step;
   logic [8:0]       addr_sum;
   logic [7:0]       addr_next;

   // ---------------------------------------------------------------------------
   // Scroll divider and offset
   // ---------------------------------------------------------------------------
   assign div_run = enable && !pause;
   assign step    = div_run && (div_q == DIV_LAST);

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      div_d = div_q;
      pos_d = pos_q;
`ifdef BANNER_BOUNCE_EN
      dir_d = dir_q;
`endif
      if (div_run) begin
         div_d = step ? '0 : div_q + 1'b1;
      end
      if (step) begin
`ifdef BANNER_BOUNCE_EN
         // Turn around at either end so base+row always stays inside the ROM.
         if (dir_q == DIR_FWD) begin
            if (pos_q == POS_TOP) begin
               dir_d = DIR_REV;
               pos_d = pos_q - 8'd1;
            end else begin
               pos_d = pos_q + 8'd1;
            end
         end else begin
            if (pos_q == 8'd0) begin
               dir_d = DIR_FWD;
               pos_d = 8'd1;
            end else begin
               pos_d = pos_q - 8'd1;
            end
         end
`else
         pos_d = (pos_q == POS_LAST) ? 8'd0 : pos_q + 8'd1;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // ROM address: (base + row) mod BANNER_LEN, 9 bits wide so the carry of
   // base+row is kept; a single conditional subtract suffices because both
   // operands are already below BANNER_LEN.
   // ---------------------------------------------------------------------------
   always_comb begin
      addr_sum  = {1'b0, base_q} + 9'(row_q);
      addr_next = addr_sum[7:0];
      if (addr_sum >= LEN_9) begin
         addr_next = 8'(addr_sum - LEN_9);
      end
   end

   // ---------------------------------------------------------------------------
   // Frame sequencer: ADDR drives the ROM, WAIT covers its registered address,
   // FETCH captures the line, HOLD waits for the driver.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      row_d        = row_q;
      rom_addr_d   = rom_addr_q;
      row_data_d   = row_data_q;
      row_idx_d    = row_idx_q;
      row_valid_d  = row_valid_q;
      frame_done_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // base is latched once per frame; later scroll steps cannot tear it.
            if (frame_start && enable) begin
               base_d  = pos_q;
               row_d   = '0;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            rom_addr_d = addr_next;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            row_data_d  = rom_data;
            row_idx_d   = row_q;
            row_valid_d = 1'b1;
            state_d     = S_HOLD;
         end
         S_HOLD: begin
            if (row_ready) begin
               row_valid_d = 1'b0;
               if (row_q == ROW_LAST) begin
                  frame_done_d = 1'b1;
                  state_d      = S_IDLE;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = S_ADDR;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         base_q       <= 8'd0;
         row_q        <= '0;
         rom_addr_q   <= 8'd0;
         // NOTE: the wide data register is reset as well because row_data is
         // a visible output that must read 0 while in reset.
         row_data_q   <= '0;
         row_idx_q    <= '0;
         row_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         div_q        <= '0;
         pos_q        <= 8'd0;
`ifdef BANNER_BOUNCE_EN
         dir_q        <= DIR_FWD;
`endif
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         row_q        <= row_d;
         rom_addr_q   <= rom_addr_d;
         row_data_q   <= row_data_d;
         row_idx_q    <= row_idx_d;
         row_valid_q  <= row_valid_d;
         frame_done_q <= frame_done_d;
         div_q        <= div_d;
         pos_q        <= pos_d;
`ifdef BANNER_BOUNCE_EN
         dir_q        <= dir_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign rom_addr   = rom_addr_q;
   assign row_data   = row_data_q;
   assign row_idx    = row_idx_q;
   assign row_valid  = row_valid_q;
   assign frame_done = frame_done_q;
   assign busy       = (state_q != S_IDLE);
   assign scroll_pos = pos_q;

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_banner_scroll_ctrl
//
// Self-checking bench for banner_scroll_ctrl with BANNER_LEN=129, DISP_ROWS=16,
// SCROLL_DIV=4. A ROM model with a registered address feeds the DUT. Each
// requested frame pushes its 16 expected rows (index and ROM address) to a
// scoreboard queue; rows are popped and compared as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_banner_scroll_ctrl;

   localparam int BANNER_LEN = 129;
   localparam int DISP_ROWS  = 16;
   localparam int SCROLL_DIV = 4;
   localparam int ROW_W      = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable;
   logic             pause;
   logic             frame_start;
   logic [7:0]       rom_addr;
   logic [56:0]      rom_data;
   logic [56:0]      row_data;
   logic [ROW_W-1:0] row_idx;
   logic             row_valid;
   logic             row_ready;
   logic             frame_done;
   logic             busy;
   logic [7:0]       scroll_pos;

   banner_scroll_ctrl #(
      .BANNER_LEN (BANNER_LEN),
      .DISP_ROWS  (DISP_ROWS),
      .SCROLL_DIV (SCROLL_DIV),
      .ROW_W      (ROW_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .pause       (pause),
      .frame_start (frame_start),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .row_data    (row_data),
      .row_idx     (row_idx),
      .row_valid   (row_valid),
      .row_ready   (row_ready),
      .frame_done  (frame_done),
      .busy        (busy),
      .scroll_pos  (scroll_pos)
   );

   always #5 clk = ~clk;

   // ROM model: registered address, data available one edge after sampling.
   logic [56:0] rom_mem [256];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int done_count = 0;
   always @(negedge clk) if (frame_done === 1'b1) done_count++;

   typedef struct {
      int idx;
      int addr;
   } row_exp_t;
   row_exp_t sb_q[$];

   int checks = 0;
   int errors = 0;
   int start_cyc;
   int first_row_cyc;

   // Request one frame; when push is set, the expected rows for base go to the
   // scoreboard. Returns at the negedge after the sampling edge.
   task automatic start_frame(input int base, input bit push);
      row_exp_t e;
      if (push) begin
         for (int r = 0; r < DISP_ROWS; r++) begin
            e.idx  = r;
            e.addr = (base + r) % BANNER_LEN;
            sb_q.push_back(e);
         end
      end
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      start_cyc   = cyc;
   endtask

   // Drain the scoreboard against the rows the DUT presents. stall_row (or -1)
   // has row_ready dropped for stall_len cycles.
   task automatic collect_frame(input int stall_row, input int stall_len);
      row_exp_t    e;
      logic [56:0] exp_data;
      int          wait_n;
      int          last_cyc;
      int          exp_gap;
      int          prev_idx;
      last_cyc = -1;
      prev_idx = -1;
      while (sb_q.size() > 0) begin
         wait_n = 0;
         while (row_valid !== 1'b1 && wait_n < 40) begin
            @(negedge clk);
            wait_n++;
         end
         if (row_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL row_timeout: row_valid=%b expected 1 within 40 cycles", row_valid);
            sb_q.delete();
            return;
         end
         e        = sb_q.pop_front();
         exp_data = rom_mem[e.addr];
         if (e.idx == 0) first_row_cyc = cyc;
         checks++;
         if (row_idx !== ROW_W'(e.idx) || row_data !== exp_data || rom_addr !== 8'(e.addr)) begin
            errors++;
            $display("FAIL row_%0d: idx=%0d addr=%0d data=%h expected idx=%0d addr=%0d data=%h",
                     e.idx, row_idx, rom_addr, row_data, e.idx, e.addr, exp_data);
         end
         if (last_cyc >= 0) begin
            exp_gap = (prev_idx == stall_row) ? 4 + stall_len : 4;
            checks++;
            if (cyc - last_cyc !== exp_gap) begin
               errors++;
               $display("FAIL row_period_%0d: %0d cycles expected %0d", e.idx, cyc - last_cyc, exp_gap);
            end
         end
         last_cyc = cyc;
         prev_idx = e.idx;
         if (e.idx == stall_row) begin
            row_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               @(negedge clk);
               checks++;
               if (row_valid !== 1'b1 || row_idx !== ROW_W'(e.idx) ||
                   row_data !== exp_data || rom_addr !== 8'(e.addr)) begin
                  errors++;
                  $display("FAIL stall_hold_%0d: valid=%b idx=%0d addr=%0d data=%h expected 1/%0d/%0d/%h",
                           s, row_valid, row_idx, rom_addr, row_data, e.idx, e.addr, exp_data);
               end
            end
            row_ready = 1'b1;
         end
         @(negedge clk);  // row has been accepted at the preceding posedge
         checks++;
         if (sb_q.size() == 0) begin
            if (frame_done !== 1'b1 || row_valid !== 1'b0) begin
               errors++;
               $display("FAIL frame_done_pulse: frame_done=%b row_valid=%b expected 1/0", frame_done, row_valid);
            end
         end else if (frame_done !== 1'b0 || row_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_accept_%0d: frame_done=%b row_valid=%b expected 0/0", e.idx, frame_done, row_valid);
         end
      end
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL frame_end: frame_done=%b busy=%b expected 0/0", frame_done, busy);
      end
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      enable      = 1'b1;
      pause       = 1'b1;
      frame_start = 1'b0;
      row_ready   = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({rom_addr, row_data, row_idx, row_valid, frame_done, busy, scroll_pos} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: addr=%0d data=%h idx=%0d valid=%b done=%b busy=%b pos=%0d expected all 0",
                  rom_addr, row_data, row_idx, row_valid, frame_done, busy, scroll_pos);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_frame();
      start_frame(0, 1'b1);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_start: busy=%b expected 1", busy);
      end
      collect_frame(-1, 0);
      // frame_start cycle, ADDR, WAIT, FETCH: row_valid visible in the 4th cycle,
      // i.e. after the 3rd edge following the one that sampled frame_start.
      checks++;
      if (first_row_cyc - start_cyc !== 3) begin
         errors++;
         $display("FAIL first_row_latency: %0d edges after start expected 3", first_row_cyc - start_cyc);
      end
   endtask

   task automatic test_backpressure();
      start_frame(0, 1'b1);
      collect_frame(3, 10);
   endtask

   task automatic test_back_to_back();
      int done_before;
      int bad;
      #1 done_before = done_count;
      start_frame(0, 1'b1);
      fork
         collect_frame(-1, 0);
         begin
            // Extra requests while busy, then enable dropped mid-frame.
            repeat (5) begin
               repeat (6) @(negedge clk);
               frame_start = 1'b1;
               @(negedge clk);
               frame_start = 1'b0;
            end
            enable = 1'b0;
            repeat (10) @(negedge clk);
            enable = 1'b1;
         end
      join
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (row_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL busy_request_queued: %0d cycles with activity after frame expected 0", bad);
      end
      #1;
      checks++;
      if (done_count - done_before !== 1) begin
         errors++;
         $display("FAIL frame_done_count: %0d pulses expected 1", done_count - done_before);
      end
   endtask

   task automatic test_reset_mid_frame();
      int done_before;
      int wait_n;
      #1 done_before = done_count;
      start_frame(0, 1'b0);
      wait_n = 0;
      while (!(row_valid === 1'b1 && row_idx === 4'd7) && wait_n < 100) begin
         @(negedge clk);
         wait_n++;
      end
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 4'd7) begin
         errors++;
         $display("FAIL reach_row7: valid=%b idx=%0d expected 1/7", row_valid, row_idx);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({rom_addr, row_data, row_idx, row_valid, frame_done, busy, scroll_pos} !== '0) begin
         errors++;
         $display("FAIL async_reset: addr=%0d data=%h idx=%0d valid=%b done=%b busy=%b pos=%0d expected all 0",
                  rom_addr, row_data, row_idx, row_valid, frame_done, busy, scroll_pos);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (done_count !== done_before || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_done: pulses=%0d busy=%b expected 0/0", done_count - done_before, busy);
      end
   endtask

   task automatic test_scroll_divider();
      int bad;
      // Divider is at 0 after reset and has been frozen by pause.
      @(negedge clk);
      pause = 1'b0;
      repeat (8) @(negedge clk);
      pause = 1'b1;
      checks++;
      if (scroll_pos !== 8'd2) begin
         errors++;
         $display("FAIL run_8_cycles: scroll_pos=%0d expected 2", scroll_pos);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (scroll_pos !== 8'd2) begin
         errors++;
         $display("FAIL pause_20_cycles: scroll_pos=%0d expected 2", scroll_pos);
      end
      enable = 1'b0;
      pause  = 1'b0;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy !== 1'b0 || row_valid !== 1'b0 || scroll_pos !== 8'd2) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL enable_low: %0d cycles with activity or scroll change expected 0", bad);
      end
   endtask

   task automatic test_wrap_frame();
      int wait_n;
      enable = 1'b1;
      pause  = 1'b0;
      wait_n = 0;
      while (scroll_pos !== 8'd120 && wait_n < 1000) begin
         @(negedge clk);
         wait_n++;
      end
      pause = 1'b1;
      checks++;
      if (scroll_pos !== 8'd120) begin
         errors++;
         $display("FAIL reach_pos_120: scroll_pos=%0d expected 120", scroll_pos);
      end
      // Rows 0..8 read addresses 120..128, row 9 wraps to address 0.
      start_frame(120, 1'b1);
      collect_frame(-1, 0);
   endtask

   task automatic test_scroll_wrap();
      rst_n  = 1'b0;
      enable = 1'b1;
      pause  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`ifdef BANNER_BOUNCE_EN
      repeat (SCROLL_DIV * 113) @(negedge clk);
      checks++;
      if (scroll_pos !== 8'd113) begin
         errors++;
         $display("FAIL bounce_top: scroll_pos=%0d expected 113", scroll_pos);
      end
      repeat (SCROLL_DIV) @(negedge clk);
      checks++;
      if (scroll_pos !== 8'd112) begin
         errors++;
         $display("FAIL bounce_reverse: scroll_pos=%0d expected 112", scroll_pos);
      end
      repeat (SCROLL_DIV * 112) @(negedge clk);
      checks++;
      if (scroll_pos !== 8'd0) begin
         errors++;
         $display("FAIL bounce_bottom: scroll_pos=%0d expected 0", scroll_pos);
      end
      repeat (SCROLL_DIV) @(negedge clk);
      checks++;
      if (scroll_pos !== 8'd1) begin
         errors++;
         $display("FAIL bounce_forward: scroll_pos=%0d expected 1", scroll_pos);
      end
`else
      repeat (SCROLL_DIV * 128) @(negedge clk);
      checks++;
      if (scroll_pos !== 8'd128) begin
         errors++;
         $display("FAIL scroll_last: scroll_pos=%0d expected 128", scroll_pos);
      end
      repeat (SCROLL_DIV) @(negedge clk);
      checks++;
      if (scroll_pos !== 8'd0) begin
         errors++;
         $display("FAIL scroll_wrap: scroll_pos=%0d expected 0", scroll_pos);
      end
`endif
      pause = 1'b1;
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         rom_mem[a] = {25'($urandom), $urandom};
      end
      test_reset();
      test_single_frame();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      test_scroll_divider();
`ifndef BANNER_BOUNCE_EN
      test_wrap_frame();
`endif
      test_scroll_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
